// File: rtl/rst_pkg.sv
// Shared types for the SoC reset sequencer: FSM states, reset-cause codes
// and the state-to-reset-output decode.
package rst_pkg;

  typedef enum logic [2:0] {
    HOLD       = 3'd0,
    WAIT_LOCK  = 3'd1,
    STG_MEM    = 3'd2,
    STG_PERIPH = 3'd3,
    RUN        = 3'd4,
    ASSERT     = 3'd5
  } state_e;

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_SOFT = 2'b01;
  localparam logic [1:0] CAUSE_LOCK = 2'b10;
  localparam logic [1:0] CAUSE_WDT  = 2'b11;

  // Returns {rst_mem, rst_periph, rst_core, rst_done} for a given state.
  function automatic logic [3:0] rst_decode(input state_e s);
    logic [3:0] v;
    v = 4'b1110;
    case (s)
      STG_MEM:    v = 4'b0110;
      STG_PERIPH: v = 4'b0010;
      RUN:        v = 4'b0001;
      default:    v = 4'b1110;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/rst_sync_2ff.sv
// Two-flop reset synchronizer: asserts asynchronously, releases on the
// second clock edge after the asynchronous reset deasserts.
module rst_sync_2ff (
  input  logic i_clk,
  input  logic i_rst_async,
  output logic o_rst_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst_async) begin
    if (i_rst_async) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= 1'b0;
      r_sync <= r_meta;
    end
  end

  assign o_rst_sync = r_sync;

endmodule

// File: rtl/rst_seq_ctrl.sv
// SoC reset sequencer: releases memory, peripheral and core resets in order
// once PLL lock is filtered. Define RSTSEQ_WDT_EN to honour wdt_expire.
module rst_seq_ctrl
  import rst_pkg::*;
#(
  parameter int LOCK_FILT = 4,
  parameter int STAGE_DLY = 8,
  parameter int HOLD_CYC  = 16,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_async,
  input  logic       pll_locked,
  input  logic       soft_rst_req,
  input  logic       wdt_expire,
  output logic       rst_mem,
  output logic       rst_periph,
  output logic       rst_core,
  output logic       rst_done,
  output logic [1:0] rst_cause
);

  localparam logic [CNT_W-1:0] LF_LAST = CNT_W'(LOCK_FILT - 1);
  localparam logic [CNT_W-1:0] SD_LAST = CNT_W'(STAGE_DLY - 1);
  localparam logic [CNT_W-1:0] HC_LAST = CNT_W'(HOLD_CYC - 1);

  logic             w_rst_int;
  logic             w_wdt;
  logic             r_lock_meta;
  logic             r_lock_s;
  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_cause;
  logic [3:0]       r_outs;
  state_e           w_nxt_state;
  logic [CNT_W-1:0] w_nxt_cnt;
  logic [1:0]       w_nxt_cause;

  rst_sync_2ff u_rst_sync (
    .i_clk       (clk),
    .i_rst_async (rst_async),
    .o_rst_sync  (w_rst_int)
  );

`ifdef RSTSEQ_WDT_EN
  assign w_wdt = wdt_expire;
`else
  logic w_unused_wdt;
  assign w_unused_wdt = wdt_expire;
  assign w_wdt        = 1'b0;
`endif

  // Plain CDC stage for the PLL lock; no reset needed on a pure sampler.
  always_ff @(posedge clk) begin
    r_lock_meta <= pll_locked;
    r_lock_s    <= r_lock_meta;
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt + CNT_W'(1);
    w_nxt_cause = r_cause;
    case (r_state)
      HOLD: begin
        w_nxt_state = WAIT_LOCK;
        w_nxt_cnt   = '0;
      end
      WAIT_LOCK: begin
        if (w_wdt) begin
          w_nxt_state = ASSERT;
          w_nxt_cnt   = '0;
          w_nxt_cause = CAUSE_WDT;
        end else if (soft_rst_req) begin
          w_nxt_state = ASSERT;
          w_nxt_cnt   = '0;
          w_nxt_cause = CAUSE_SOFT;
        end else if (!r_lock_s) begin
          w_nxt_cnt = '0;
        end else if (r_cnt == LF_LAST) begin
          w_nxt_state = STG_MEM;
          w_nxt_cnt   = '0;
        end
      end
      STG_MEM, STG_PERIPH, RUN: begin
        // Lock loss outranks watchdog, which outranks a soft request.
        if (!r_lock_s) begin
          w_nxt_state = ASSERT;
          w_nxt_cnt   = '0;
          w_nxt_cause = CAUSE_LOCK;
        end else if (w_wdt) begin
          w_nxt_state = ASSERT;
          w_nxt_cnt   = '0;
          w_nxt_cause = CAUSE_WDT;
        end else if (soft_rst_req) begin
          w_nxt_state = ASSERT;
          w_nxt_cnt   = '0;
          w_nxt_cause = CAUSE_SOFT;
        end else if (r_state == RUN) begin
          w_nxt_cnt = '0;
        end else if (r_cnt == SD_LAST) begin
          w_nxt_state = (r_state == STG_MEM) ? STG_PERIPH : RUN;
          w_nxt_cnt   = '0;
        end
      end
      ASSERT: begin
        if (r_cnt == HC_LAST) begin
          w_nxt_state = WAIT_LOCK;
          w_nxt_cnt   = '0;
        end
      end
      default: begin
        w_nxt_state = HOLD;
        w_nxt_cnt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so each reset changes on the
  // same edge as the state transition that causes it.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      r_state <= HOLD;
      r_cnt   <= '0;
      r_cause <= CAUSE_POR;
      r_outs  <= 4'b1110;
    end else if (w_rst_int) begin
      r_state <= HOLD;
      r_cnt   <= '0;
      r_cause <= CAUSE_POR;
      r_outs  <= 4'b1110;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_cause <= w_nxt_cause;
      r_outs  <= rst_decode(w_nxt_state);
    end
  end

  assign {rst_mem, rst_periph, rst_core, rst_done} = r_outs;
  assign rst_cause = r_cause;

endmodule
